// File: rtl/tdm_rx_deser_if.sv
// rtl/tdm_rx_deser_if.sv - received slot word and frame status bundle
interface tdm_rx_deser_if #(
  parameter int SLOTS     = 8,
  parameter int DATA_BITS = 24
);
  localparam int NUM_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  logic [DATA_BITS-1:0] ch_data;
  logic [NUM_W-1:0]     ch_num;
  logic                 ch_valid;
  logic                 frame_start;
  logic                 locked;
  logic                 sync_err;

  modport master (output ch_data, ch_num, ch_valid, frame_start, locked, sync_err);
  modport slave  (input  ch_data, ch_num, ch_valid, frame_start, locked, sync_err);
endinterface

// File: rtl/tdm_rx_deser.sv
// rtl/tdm_rx_deser.sv - TDM receive deserializer locked to the wclk frame sync
module tdm_rx_deser #(
  parameter int SLOTS     = 8,
  parameter int SLOT_BITS = 32,
  parameter int DATA_BITS = 24,
  parameter int DELAY     = 1
) (
  input  logic           bclk,
  input  logic           rst_n,
  input  logic           wclk,
  input  logic           tdm_in,
  tdm_rx_deser_if.master ch
);
  localparam int            FRAME = SLOTS * SLOT_BITS;
  localparam int            CW    = $clog2(FRAME);
  localparam int            NW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [CW-1:0] LAST  = CW'(FRAME - 1);

  typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

  state_t               state, state_nx;
  logic                 wclk_d;
  logic [CW-1:0]        cyc;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] word;
  logic [CW-1:0]        bit_k;
  logic [31:0]          sbit;
  logic [NW-1:0]        slot;
  logic                 rise, at_last;
  logic                 early, missing, take, complete;

  assign rise    = wclk && !wclk_d;
  assign at_last = (cyc == LAST);
  assign word    = (shift << 1) | DATA_BITS'(tdm_in);
  assign sbit    = 32'(bit_k) % SLOT_BITS;
  assign slot    = NW'(32'(bit_k) / SLOT_BITS);

  // Frame bit index of the tdm_in sample taken this cycle; with no delay bit 0 lands on the edge itself
  always_comb begin
    bit_k = cyc;
    if (DELAY == 0) begin
      bit_k = (rise || at_last) ? '0 : cyc + 1'b1;
    end
  end

  // Lock state register
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
    end else begin
      state <= state_nx;
    end
  end

  // Lock on any rising wclk; drop lock only when the expected edge fails to show up
  always_comb begin
    state_nx = state;
    if (state == HUNT) begin
      if (rise) state_nx = RUN;
    end else begin
      if (missing) state_nx = HUNT;
    end
  end

  // Classify the frame edge and decide whether this cycle's sample belongs to a live slot
  always_comb begin
    early   = 1'b0;
    missing = 1'b0;
    take    = 1'b0;
    if (state == RUN) begin
      early   = rise && !at_last;
      missing = !rise && at_last;
    end
    if (DELAY == 0) begin
      take = rise || ((state == RUN) && !at_last);
    end else begin
      take = (state == RUN) && (rise == at_last);
    end
    complete = take && !early && (sbit == 32'(DATA_BITS - 1));
  end

  // Frame counter, shift register and registered strobes
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      wclk_d         <= 1'b1;
      cyc            <= '0;
      shift          <= '0;
      ch.ch_data     <= '0;
      ch.ch_num      <= '0;
      ch.ch_valid    <= 1'b0;
      ch.frame_start <= 1'b0;
      ch.locked      <= 1'b0;
      ch.sync_err    <= 1'b0;
    end else begin
      wclk_d <= wclk;
      if (rise || (state != RUN) || at_last) begin
        cyc <= '0;
      end else begin
        cyc <= cyc + 1'b1;
      end
      if (take) begin
        shift <= word;
      end
      ch.ch_valid <= complete;
      if (complete) begin
        ch.ch_data <= word;
        ch.ch_num  <= slot;
      end
      ch.frame_start <= rise;
      ch.sync_err    <= early || missing;
      ch.locked      <= (state_nx == RUN);
    end
  end
endmodule
